ysyx_25060170_ifu_fetch: RTL and testbench

- Instruction-fetch stage, directly upstream of the decode stage.
- Owns the fetch PC and issues one 32-bit instruction request at a time to instruction memory over a valid/ready interface.
- Buffers returned {pc, inst} pairs in a small in-order fetch queue; the queue head is the IF/ID register seen by decode.
- Applies branch/JALR redirects from decode: flushes queued and in-flight fetches and restarts at the target.

---
 rtl/ysyx_25060170_ifu_fetch.sv | 209 ++++++++++++++++++++
 tb/tb_ysyx_25060170_ifu_fetch.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060170_ifu_fetch.sv
// ysyx_25060170_ifu_fetch: instruction-fetch stage feeding decode.
//
// Owns the fetch PC and issues one word-aligned 32-bit request at a time to
// instruction memory (valid/ready request, single-cycle response strobe).
// Returned {pc, inst} pairs are pushed into a small in-order fetch queue.
// The queue head is the IF/ID register seen by decode. A redirect from
// decode pops the branch head, flushes everything else, drops any fetch
// still in flight and restarts fetching at the aligned target.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   jump_ena/jump_pc redirect request and target from decode
//   id_ready        decode can take the head this cycle
//   id_stall        decode stall; holds the head and masks jump_ena
//   imem_req_*      fetch request channel (valid/ready, addr)
//   imem_rsp_*      fetch response (valid strobe, instruction word)
//   if_valid        queue head valid
//   pc_o, inst_o    head PC / instruction (zero when the queue is empty)

module ysyx_25060170_ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_ena,
  input  logic [31:0] jump_pc,
  input  logic        id_ready,
  input  logic        id_stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  localparam int unsigned PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

  // FETCH: may issue. WAIT: response pending and wanted. DROP: response
  // pending but stale, discard it when it shows up.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [31:0]      pc_r;
  logic [31:0]      pc_nxt_s;
  logic [31:0]      target_s;
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [31:0]      pc_q_r   [FQ_DEPTH];
  logic [31:0]      inst_q_r [FQ_DEPTH];
  logic             if_valid_s;
  logic             fire_s;
  logic             redirect_s;
  logic             req_valid_s;
  logic             req_hs_s;
  logic             push_s;

  assign if_valid_s = (count_r != {CNT_W{1'b0}});
  assign fire_s     = if_valid_s & id_ready & ~id_stall;
  // A stalled decode re-evaluates its jump next cycle, so it is masked here.
  assign redirect_s = jump_ena & id_ready & ~id_stall;
  assign target_s   = jump_pc & 32'hFFFF_FFFC;

  // Issue only with a free queue slot: together with the single outstanding
  // request this makes queue overflow impossible.
  assign req_valid_s = ~rst & (state_r == ST_FETCH) & (count_r < DEPTH_C);
  assign req_hs_s    = req_valid_s & imem_req_ready;

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = pc_r;
  assign if_valid       = if_valid_s;
  assign pc_o           = if_valid_s ? pc_q_r[head_r]   : 32'h0000_0000;
  assign inst_o         = if_valid_s ? inst_q_r[head_r] : 32'h0000_0000;

  // Next-state and push decision of the request/response FSM.
  always_comb begin
    state_nxt_s = state_r;
    push_s      = 1'b0;
    case (state_r)
      ST_FETCH: begin
        // A request accepted alongside a redirect carried the old PC.
        if (req_hs_s && redirect_s) begin
          state_nxt_s = ST_DROP;
        end else if (req_hs_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          state_nxt_s = ST_FETCH;
          push_s      = ~redirect_s;
        end else if (redirect_s) begin
          state_nxt_s = ST_DROP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (imem_rsp_valid) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      default: begin
        state_nxt_s = ST_FETCH;
      end
    endcase
  end

  // Next fetch PC: redirect target wins over sequential advance.
  always_comb begin
    pc_nxt_s = pc_r;
    if (redirect_s) begin
      pc_nxt_s = target_s;
    end else if (push_s) begin
      pc_nxt_s = pc_r + 32'd4;
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // FSM state and fetch PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FETCH;
      pc_r    <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue outright
  // (branch head leaves for EX, the rest is flushed).
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else if (redirect_s) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (fire_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({push_s, fire_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue payload; validity is tracked by count_r so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_q_r[tail_r]   <= pc_r;
      inst_q_r[tail_r] <= imem_rsp_data;
    end
  end

  ysyx_25060170_ifu_fetch_chk u_chk (
    .clk  (clk),
    .rst  (rst),
    .push (push_s),
    .pop  (fire_s),
    .full (count_r == DEPTH_C)
  );

endmodule

// ysyx_25060170_ifu_fetch_chk: invariants of the fetch queue.
// Ports: clk, rst; push/pop strobes and full flag of the queue.
module ysyx_25060170_ifu_fetch_chk (
  input logic clk,
  input logic rst,
  input logic push,
  input logic pop,
  input logic full
);

  property p_no_overflow;
    @(posedge clk) disable iff (rst) !(push && !pop && full);
  endproperty

  a_no_overflow: assert property (p_no_overflow);

endmodule

// File: tb/tb_ysyx_25060170_ifu_fetch.sv
// Bench for ysyx_25060170_ifu_fetch: directed steps from the fetch scenarios,
// then randomized traffic checked against a program-order reference model
// (the head must always be the next instruction in program order, with
// redirects restarting the order at the aligned target).
module tb_ysyx_25060170_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_ena;
  logic [31:0] jump_pc;
  logic        id_ready;
  logic        id_stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  int n_cmp = 0;
  int n_err = 0;

  // reference model / memory model state
  logic [31:0] exp_pc;
  bit          check_en;
  bit          mem_pend;
  int          mem_cnt;
  int          mem_lat;
  logic [31:0] mem_addr;
  int          n_hs;
  int          n_fire;

  // per-cycle samples
  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_if_valid;
  logic [31:0] s_pc;
  logic [31:0] s_inst;

  always #5 clk = ~clk;

  ysyx_25060170_ifu_fetch #(
    .RESET_PC (RESET_PC),
    .FQ_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .jump_ena       (jump_ena),
    .jump_pc        (jump_pc),
    .id_ready       (id_ready),
    .id_stall       (id_stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .pc_o           (pc_o),
    .inst_o         (inst_o)
  );

  // Instruction memory contents; address 0x8000_0000 holds 0x13 (nop).
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    logic [31:0] off;
    off = a ^ 32'h8000_0000;
    return (off * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic logic [31:0] w1(input logic b);
    return {31'b0, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic drv(input logic j, input logic [31:0] jpc, input logic rdy,
                     input logic stl, input logic mrdy);
    jump_ena       = j;
    jump_pc        = jpc;
    id_ready       = rdy;
    id_stall       = stl;
    imem_req_ready = mrdy;
  endtask

  // One clock cycle: present the memory response, sample, check against the
  // program-order model, advance the memory model, then cross the edge.
  task automatic cycle();
    logic redir;
    logic fire;
    if (mem_pend && mem_cnt == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_fn(mem_addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    #1;
    s_req_valid = imem_req_valid;
    s_req_addr  = imem_req_addr;
    s_if_valid  = if_valid;
    s_pc        = pc_o;
    s_inst      = inst_o;
    redir = jump_ena & id_ready & ~id_stall;
    fire  = s_if_valid & id_ready & ~id_stall;
    if (check_en) begin
      if (s_if_valid) begin
        chk("head_pc", s_pc, exp_pc);
        chk("head_inst", s_inst, mem_fn(exp_pc));
      end else begin
        chk("empty_pc", s_pc, 32'h0);
        chk("empty_inst", s_inst, 32'h0);
      end
      if (s_req_valid) begin
        chk("one_outstanding", w1(mem_pend), 32'h0);
        chk("addr_align", {30'b0, s_req_addr[1:0]}, 32'h0);
      end
      if (fire || (redir && s_if_valid)) n_fire++;
      if (redir) exp_pc = jump_pc & 32'hFFFF_FFFC;
      else if (fire) exp_pc = exp_pc + 32'd4;
    end
    if (imem_rsp_valid) mem_pend = 1'b0;
    else if (mem_pend) mem_cnt--;
    if (s_req_valid && imem_req_ready) begin
      mem_pend = 1'b1;
      mem_addr = s_req_addr;
      mem_cnt  = mem_lat - 1;
      n_hs++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    check_en = 1'b0;
    mem_pend = 1'b0;
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cycle();
    cycle();
    chk("rst_req_valid", w1(s_req_valid), 32'h0);
    chk("rst_if_valid", w1(s_if_valid), 32'h0);
    chk("rst_pc_o", s_pc, 32'h0);
    chk("rst_inst_o", s_inst, 32'h0);
    rst      = 1'b0;
    exp_pc   = RESET_PC;
    check_en = 1'b1;
    n_hs     = 0;
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] tgt;
    rst = 1'b1;
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    mem_lat = 1; mem_cnt = 0; mem_addr = 32'h0; mem_pend = 1'b0;
    n_hs = 0; n_fire = 0; exp_pc = RESET_PC; check_en = 1'b0;
    @(posedge clk);
    #1;

    // 1: first fetch latency
    do_reset();
    mem_lat = 1;
    drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    cycle();
    chk("c1_req_valid", w1(s_req_valid), 32'h1);
    chk("c1_req_addr", s_req_addr, 32'h8000_0000);
    cycle();
    chk("c2_if_valid", w1(s_if_valid), 32'h0);
    chk("c2_req_valid", w1(s_req_valid), 32'h0);
    cycle();
    chk("c3_if_valid", w1(s_if_valid), 32'h1);
    chk("c3_pc_o", s_pc, 32'h8000_0000);
    chk("c3_inst_o", s_inst, 32'h0000_0013);
    chk("c3_req_addr", s_req_addr, 32'h8000_0004);

    // 2: decode blocked, queue fills to depth then pops in order
    do_reset();
    mem_lat = 1;
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    repeat (10) cycle();
    chk("full_req_valid", w1(s_req_valid), 32'h0);
    chk("full_fetches", 32'(n_hs), 32'd2);
    chk("full_head_pc", s_pc, 32'h8000_0000);
    drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    cycle();
    chk("pop0_pc", s_pc, 32'h8000_0000);
    chk("pop0_req_valid", w1(s_req_valid), 32'h0);
    cycle();
    chk("pop1_pc", s_pc, 32'h8000_0004);
    chk("resume_req_valid", w1(s_req_valid), 32'h1);
    chk("resume_addr", s_req_addr, 32'h8000_0008);

    // 3: redirect while waiting, stale response 3 cycles later
    do_reset();
    mem_lat = 4;
    drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    cycle();
    mem_lat = 1;
    drv(1'b1, 32'h8000_0100, 1'b1, 1'b0, 1'b1);
    cycle();
    drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    cycle();
    cycle();
    chk("drop_req_valid", w1(s_req_valid), 32'h0);
    cycle();
    chk("stale_if_valid", w1(s_if_valid), 32'h0);
    cycle();
    chk("redir_req_valid", w1(s_req_valid), 32'h1);
    chk("redir_req_addr", s_req_addr, 32'h8000_0100);
    cycle();
    cycle();
    chk("redir_head_valid", w1(s_if_valid), 32'h1);
    chk("redir_head_pc", s_pc, 32'h8000_0100);
    chk("redir_head_inst", s_inst, mem_fn(32'h8000_0100));

    // 4: stalled jump ignored, then real redirect to unaligned target
    do_reset();
    mem_lat = 1;
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    repeat (6) cycle();
    drv(1'b1, 32'h8000_0500, 1'b1, 1'b1, 1'b1);
    cycle();
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle();
    chk("stall_jump_valid", w1(s_if_valid), 32'h1);
    chk("stall_jump_head", s_pc, 32'h8000_0000);
    drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    cycle();
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle();
    chk("stall_jump_req_valid", w1(s_req_valid), 32'h1);
    chk("stall_jump_pc", s_req_addr, 32'h8000_0008);
    cycle();
    drv(1'b1, 32'h8000_0203, 1'b1, 1'b0, 1'b1);
    cycle();
    chk("pre_flush_valid", w1(s_if_valid), 32'h1);
    // 5: handshake together with redirect, then response together with redirect
    drv(1'b1, 32'h8000_0300, 1'b1, 1'b0, 1'b1);
    cycle();
    chk("flush_if_valid", w1(s_if_valid), 32'h0);
    chk("align_req_valid", w1(s_req_valid), 32'h1);
    chk("align_req_addr", s_req_addr, 32'h8000_0200);
    drv(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    cycle();
    chk("hs_redir_drop_valid", w1(s_req_valid), 32'h0);
    cycle();
    chk("hs_redir_addr", s_req_addr, 32'h8000_0300);
    drv(1'b1, 32'h8000_0400, 1'b1, 1'b0, 1'b1);
    cycle();
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle();
    chk("rsp_redir_if_valid", w1(s_if_valid), 32'h0);
    chk("rsp_redir_req_valid", w1(s_req_valid), 32'h1);
    chk("rsp_redir_addr", s_req_addr, 32'h8000_0400);
    cycle();
    mem_lat = 3;
    cycle();
    chk("target_head_pc", s_pc, 32'h8000_0400);
    chk("target_head_inst", s_inst, mem_fn(32'h8000_0400));

    // 6: reset while waiting; the late response must be ignored
    check_en = 1'b0;
    rst = 1'b1;
    cycle();
    chk("rst_gates_req", w1(s_req_valid), 32'h0);
    rst = 1'b0;
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("post_rst_if_valid", w1(s_if_valid), 32'h0);
    chk("post_rst_req_valid", w1(s_req_valid), 32'h1);
    chk("post_rst_req_addr", s_req_addr, 32'h8000_0000);
    cycle();
    mem_lat = 1;
    exp_pc = RESET_PC;
    check_en = 1'b1;
    drv(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle();
    chk("late_rsp_ignored", w1(s_if_valid), 32'h0);
    chk("restart_addr", s_req_addr, 32'h8000_0000);
    cycle();
    cycle();
    chk("restart_pc", s_pc, 32'h8000_0000);
    chk("restart_inst", s_inst, 32'h0000_0013);

    // 7: randomized traffic against the program-order model
    n_fire = 0;
    for (int i = 0; i < 3000; i++) begin
      rnd = $urandom;
      mem_lat = $urandom_range(1, 3);
      if (rnd[22:20] == 3'd0) tgt = 32'hFFFF_FFF4 | {30'b0, rnd[1:0]};
      else tgt = {16'h8000, rnd[15:0]};
      drv(($urandom_range(0, 11) == 0), tgt, ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0));
      cycle();
    end
    chk("progress", w1(n_fire >= 200), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
